// File: rtl/mfp_ahb_intc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mfp_ahb_intc_pkg
// Description : Shared constants for the MIPSfpga AHB-Lite interrupt
//               controller. Byte offsets of the register window (decoded on
//               HADDR[4:2]), the CTRL bit selecting EIC mode, output widths,
//               and the register-select enum used by the bus decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mfp_ahb_intc_pkg;

  // Byte offsets of the register window; only bits [4:2] are decoded.
  localparam logic [7:0] MFP_INTC_PEND_OFF = 8'h00;  // RO pending
  localparam logic [7:0] MFP_INTC_EN_OFF   = 8'h04;  // RW enable
  localparam logic [7:0] MFP_INTC_MODE_OFF = 8'h08;  // RW 1=edge, 0=level
  localparam logic [7:0] MFP_INTC_CLR_OFF  = 8'h0C;  // WO write-1-to-clear
  localparam logic [7:0] MFP_INTC_ACT_OFF  = 8'h10;  // RO PEND & EN
  localparam logic [7:0] MFP_INTC_VEC_OFF  = 8'h14;  // RO lowest active + 1
  localparam logic [7:0] MFP_INTC_CTRL_OFF = 8'h18;  // RW control
  localparam logic [7:0] MFP_INTC_RSVD_OFF = 8'h1C;  // reads 0

  // CTRL bit that switches the core interface from SI_Int to EIC vectoring.
  localparam int MFP_INTC_CTRL_EIC = 0;

  // Widths of the core-side interrupt outputs.
  localparam int MFP_INTC_SI_W  = 8;
  localparam int MFP_INTC_VEC_W = 6;

  // Word-select of the register window, derived from the byte offsets so the
  // two can never drift apart.
  typedef enum logic [2:0] {
    INTC_REG_PEND = MFP_INTC_PEND_OFF[4:2],
    INTC_REG_EN   = MFP_INTC_EN_OFF[4:2],
    INTC_REG_MODE = MFP_INTC_MODE_OFF[4:2],
    INTC_REG_CLR  = MFP_INTC_CLR_OFF[4:2],
    INTC_REG_ACT  = MFP_INTC_ACT_OFF[4:2],
    INTC_REG_VEC  = MFP_INTC_VEC_OFF[4:2],
    INTC_REG_CTRL = MFP_INTC_CTRL_OFF[4:2],
    INTC_REG_RSVD = MFP_INTC_RSVD_OFF[4:2]
  } intc_reg_e;

  // An AHB-Lite transfer is live when the slave is selected and HTRANS is
  // NONSEQ or SEQ (HTRANS[1] set).
  function automatic logic intc_live(input logic hsel, input logic [1:0] htrans);
    return hsel & htrans[1];
  endfunction

endpackage : mfp_ahb_intc_pkg
`default_nettype wire

// File: rtl/mfp_intc_sync.sv
`default_nettype none
// ============================================================================
// Module      : mfp_intc_sync
// Description : Per-source input conditioning for the interrupt controller.
//               A SYNC_STAGES-deep flop chain brings the asynchronous source
//               into the clk domain, and one further flop holds the previous
//               synchronized value so a rising edge can be detected.
// Ports       : clk      - the only clock
//               rst_n    - asynchronous active-low reset
//               i_async  - raw asynchronous interrupt source
//               o_s      - synchronized level
//               o_rise   - synchronized level high now, low one cycle ago
// Revision    : 1.0 - initial release
// ============================================================================
module mfp_intc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_s,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_p    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_p    <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_s    = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_p;

endmodule : mfp_intc_sync
`default_nettype wire

// File: rtl/mfp_ahb_intc.sv
`default_nettype none
// ============================================================================
// Module      : mfp_ahb_intc
// Description : AHB-Lite interrupt controller for MIPSfpga. N_SRC async
//               sources with per-source enable, level/rising-edge mode and
//               sticky edge pending bits. Drives the core SI_Int[7:0] pins
//               (legacy fold, source i onto pin i mod 8) or, in EIC mode, a
//               fixed-priority vector (lowest index wins, reported as i+1).
// Ports       : HCLK, HRESETn            - clock, async active-low reset
//               HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA - AHB-Lite slave inputs
//               HRDATA/HREADY/HRESP      - AHB-Lite slave outputs (no waits)
//               IRQ_In[N_SRC]            - raw asynchronous sources
//               SI_Int[8]                - core interrupt pins (registered)
//               EIC_Vector[6]            - core EIC vector (registered)
//               EIC_Present              - CTRL EIC bit
// Parameters  : N_SRC (1..32), SYNC_STAGES (>=2)
// Revision    : 1.0 - initial release
// ============================================================================
module mfp_ahb_intc
  import mfp_ahb_intc_pkg::*;
#(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [31:0]               HWDATA,
  output logic [31:0]               HRDATA,
  output logic                      HREADY,
  output logic                      HRESP,
  input  logic [N_SRC-1:0]          IRQ_In,
  output logic [MFP_INTC_SI_W-1:0]  SI_Int,
  output logic [MFP_INTC_VEC_W-1:0] EIC_Vector,
  output logic                      EIC_Present
);

  // --------------------------------------------------------------------------
  // Source conditioning
  // --------------------------------------------------------------------------
  logic [N_SRC-1:0] w_s;
  logic [N_SRC-1:0] w_rise;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      mfp_intc_sync #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .i_async (IRQ_In[gi]),
        .o_s     (w_s[gi]),
        .o_rise  (w_rise[gi])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // AHB address phase capture. HREADY is constant 1, so every cycle is the
  // address phase of whatever is on the bus.
  // --------------------------------------------------------------------------
  logic      r_wr;
  logic      r_rd;
  intc_reg_e r_idx;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_idx <= INTC_REG_PEND;
    end else begin
      r_wr  <= intc_live(HSEL, HTRANS) &  HWRITE;
      r_rd  <= intc_live(HSEL, HTRANS) & ~HWRITE;
      r_idx <= intc_reg_e'(HADDR[4:2]);
    end
  end

  // Data-phase write strobes per register.
  logic w_wr_en;
  logic w_wr_mode;
  logic w_wr_clr;
  logic w_wr_ctrl;

  assign w_wr_en   = r_wr && (r_idx == INTC_REG_EN);
  assign w_wr_mode = r_wr && (r_idx == INTC_REG_MODE);
  assign w_wr_clr  = r_wr && (r_idx == INTC_REG_CLR);
  assign w_wr_ctrl = r_wr && (r_idx == INTC_REG_CTRL);

  // Bits at or above N_SRC are simply not stored.
  logic [N_SRC-1:0] w_wdata;
  assign w_wdata = HWDATA[N_SRC-1:0];

  // --------------------------------------------------------------------------
  // Control registers and sticky edge latches
  // --------------------------------------------------------------------------
  logic [N_SRC-1:0] r_en;
  logic [N_SRC-1:0] r_mode;
  logic [N_SRC-1:0] r_latch;
  logic             r_ctrl;

  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_flip;

  // A MODE write that changes a bit discards that source's latched edge, so
  // switching modes never leaves a stale pending behind.
  assign w_clr  = w_wr_clr  ? w_wdata            : '0;
  assign w_flip = w_wr_mode ? (w_wdata ^ r_mode) : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_en    <= '0;
      r_mode  <= '0;
      r_latch <= '0;
      r_ctrl  <= 1'b0;
    end else begin
      if (w_wr_en)   r_en   <= w_wdata;
      if (w_wr_mode) r_mode <= w_wdata;
      if (w_wr_ctrl) r_ctrl <= HWDATA[MFP_INTC_CTRL_EIC];
      // The set term is OR-ed in last so a new edge beats a same-cycle clear.
      r_latch <= (r_latch & ~w_clr & ~w_flip) | (w_rise & r_mode);
    end
  end

  // --------------------------------------------------------------------------
  // Pending / active / vector
  // --------------------------------------------------------------------------
  logic [N_SRC-1:0]          w_pend;
  logic [N_SRC-1:0]          w_act;
  logic [MFP_INTC_VEC_W-1:0] w_vec;
  logic [MFP_INTC_SI_W-1:0]  w_fold;

  // Level sources show the synchronized input directly; edge sources show
  // their sticky latch.
  assign w_pend = (r_mode & r_latch) | (~r_mode & w_s);
  assign w_act  = w_pend & r_en;

  // Fixed-priority encoder: scanning downward lets the lowest active index
  // overwrite any higher one.
  always_comb begin
    w_vec = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_act[i]) w_vec = MFP_INTC_VEC_W'(i + 1);
    end
  end

  // Legacy fold: source i drives pin i mod 8.
  always_comb begin
    w_fold = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_fold[i[2:0]] = w_fold[i[2:0]] | w_act[i];
    end
  end

  // --------------------------------------------------------------------------
  // Registered core-side outputs
  // --------------------------------------------------------------------------
  logic [MFP_INTC_SI_W-1:0]  r_si;
  logic [MFP_INTC_VEC_W-1:0] r_vec;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_si  <= '0;
      r_vec <= '0;
    end else begin
      r_si  <= r_ctrl ? '0    : w_fold;
      r_vec <= r_ctrl ? w_vec : '0;
    end
  end

  assign SI_Int      = r_si;
  assign EIC_Vector  = r_vec;
  assign EIC_Present = r_ctrl;

  // --------------------------------------------------------------------------
  // Read mux: combinational from the registers during the data phase, zero
  // otherwise. CLR and the reserved word always read zero.
  // --------------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (r_rd) begin
      case (r_idx)
        INTC_REG_PEND: w_rdata[N_SRC-1:0]          = w_pend;
        INTC_REG_EN:   w_rdata[N_SRC-1:0]          = r_en;
        INTC_REG_MODE: w_rdata[N_SRC-1:0]          = r_mode;
        INTC_REG_ACT:  w_rdata[N_SRC-1:0]          = w_act;
        INTC_REG_VEC:  w_rdata[MFP_INTC_VEC_W-1:0] = w_vec;
        INTC_REG_CTRL: w_rdata[MFP_INTC_CTRL_EIC]  = r_ctrl;
        default:       w_rdata                     = '0;
      endcase
    end
  end

  assign HRDATA = w_rdata;
  assign HREADY = 1'b1;
  assign HRESP  = 1'b0;

  // Bus inputs that carry no information for a word-only, 8-register slave.
  logic w_unused;
  assign w_unused = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HSIZE, HWDATA};

endmodule : mfp_ahb_intc
`default_nettype wire

// File: tb/tb_mfp_ahb_intc.sv
`default_nettype none
// ============================================================================
// Module      : tb_mfp_ahb_intc
// Description : Self-checking bench for mfp_ahb_intc (N_SRC=16). Directed
//               sequences for reset, edge/level behaviour, EIC priority,
//               set/clear collision, legacy fold and async reset, followed by
//               randomized bus traffic and source toggling. A history-based
//               reference model predicts outputs and read data every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mfp_ahb_intc;

  localparam int c_n_src = 16;
  localparam int c_sync  = 2;

  localparam logic [2:0] c_pend = 3'd0;
  localparam logic [2:0] c_en   = 3'd1;
  localparam logic [2:0] c_mode = 3'd2;
  localparam logic [2:0] c_clr  = 3'd3;
  localparam logic [2:0] c_act  = 3'd4;
  localparam logic [2:0] c_vec  = 3'd5;
  localparam logic [2:0] c_ctrl = 3'd6;
  localparam logic [2:0] c_rsvd = 3'd7;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL    = 1'b0;
  logic [31:0] HADDR   = '0;
  logic [1:0]  HTRANS  = '0;
  logic        HWRITE  = 1'b0;
  logic [2:0]  HSIZE   = 3'd2;
  logic [31:0] HWDATA  = '0;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [15:0] IRQ_In  = '0;
  logic [7:0]  SI_Int;
  logic [5:0]  EIC_Vector;
  logic        EIC_Present;

  always #5 HCLK = ~HCLK;

  mfp_ahb_intc #(
    .N_SRC       (c_n_src),
    .SYNC_STAGES (c_sync)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HWDATA      (HWDATA),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .IRQ_In      (IRQ_In),
    .SI_Int      (SI_Int),
    .EIC_Vector  (EIC_Vector),
    .EIC_Present (EIC_Present)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. hist[0] is IRQ_In as sampled at the latest edge, hist[k]
  // the value k edges earlier. The synchronized level is the input from
  // SYNC_STAGES-1 edges back; a rising edge is s high while the sample one
  // edge older was low.
  // --------------------------------------------------------------------------
  logic [15:0] hist [0:7];
  logic [15:0] m_en, m_mode, m_latch;
  logic        m_ctrl;
  logic [7:0]  exp_si;
  logic [5:0]  exp_vec;
  logic        dp_wr, dp_rd;
  logic [2:0]  dp_idx;
  logic [31:0] last_rd;

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) hist[k] = '0;
    m_en = '0; m_mode = '0; m_latch = '0; m_ctrl = 1'b0;
    exp_si = '0; exp_vec = '0;
    dp_wr = 1'b0; dp_rd = 1'b0; dp_idx = '0;
  endfunction

  function automatic logic [15:0] m_pend();
    logic [15:0] r;
    for (int i = 0; i < 16; i++)
      r[i] = m_mode[i] ? m_latch[i] : hist[c_sync-1][i];
    return r;
  endfunction

  function automatic logic [5:0] m_lowest(input logic [15:0] act);
    for (int i = 0; i < 16; i++)
      if (act[i]) return 6'(i + 1);
    return 6'd0;
  endfunction

  function automatic logic [7:0] m_fold(input logic [15:0] act);
    logic [7:0] r = '0;
    for (int i = 0; i < 16; i++)
      if (act[i]) r[i % 8] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] idx);
    logic [15:0] act = m_pend() & m_en;
    case (idx)
      c_pend:  return {16'd0, m_pend()};
      c_en:    return {16'd0, m_en};
      c_mode:  return {16'd0, m_mode};
      c_act:   return {16'd0, act};
      c_vec:   return {26'd0, m_lowest(act)};
      c_ctrl:  return {31'd0, m_ctrl};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_edge();
    logic [15:0] act_old, rise, wd, clr, flip, mode_old;
    if (!HRESETn) begin
      model_reset();
      return;
    end
    act_old  = m_pend() & m_en;
    exp_si   = m_ctrl ? 8'd0 : m_fold(act_old);
    exp_vec  = m_ctrl ? m_lowest(act_old) : 6'd0;
    rise     = hist[c_sync-1] & ~hist[c_sync];
    mode_old = m_mode;
    wd = HWDATA[15:0]; clr = '0; flip = '0;
    if (dp_wr) begin
      case (dp_idx)
        c_en:   m_en = wd;
        c_mode: begin flip = wd ^ m_mode; m_mode = wd; end
        c_clr:  clr = wd;
        c_ctrl: m_ctrl = HWDATA[0];
        default: ;
      endcase
    end
    m_latch = (m_latch & ~clr & ~flip) | (rise & mode_old);
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = IRQ_In;
    dp_wr  = HSEL & HTRANS[1] & HWRITE;
    dp_rd  = HSEL & HTRANS[1] & ~HWRITE;
    dp_idx = HADDR[4:2];
  endfunction

  // --------------------------------------------------------------------------
  // Cycle stepping and bus tasks. Inputs change 1 time unit after a rising
  // edge; outputs are compared at that same point.
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge HCLK);
    model_edge();
    #1;
    chk_val("si_int", {24'd0, SI_Int}, {24'd0, exp_si});
    chk_val("eic_vector", {26'd0, EIC_Vector}, {26'd0, exp_vec});
    chk_val("eic_present", {31'd0, EIC_Present}, {31'd0, m_ctrl});
    if (dp_rd) begin
      last_rd = HRDATA;
      chk_val("hrdata", HRDATA, m_read(dp_idx));
    end
  endtask

  task automatic addr_phase(input logic [2:0] idx, input logic wr);
    HSEL   = 1'b1;
    HTRANS = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
    HWRITE = wr;
    HADDR  = $urandom;
    HADDR[4:2] = idx;
    HSIZE  = 3'($urandom_range(0, 2));
  endtask

  task automatic bus_release();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic bus_idle();
    bus_release();
    tick();
  endtask

  task automatic bus_write(input logic [2:0] idx, input logic [31:0] data);
    addr_phase(idx, 1'b1);
    tick();
    bus_release();
    HWDATA = data;
    tick();
  endtask

  task automatic bus_read(input logic [2:0] idx, output logic [31:0] data);
    addr_phase(idx, 1'b0);
    tick();
    bus_release();
    data = last_rd;
  endtask

  task automatic write_then_read(input logic [2:0] idx, input logic [31:0] data,
                                 output logic [31:0] rd);
    addr_phase(idx, 1'b1);
    tick();
    HWDATA = data;
    addr_phase(idx, 1'b0);
    tick();
    bus_release();
    rd = last_rd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    model_reset();
    last_rd = '0;

    // Reset state and every register reads zero.
    repeat (3) tick();
    chk_val("hready", {31'd0, HREADY}, 32'd1);
    chk_val("hresp", {31'd0, HRESP}, 32'd0);
    HRESETn = 1'b1;
    tick();
    for (int r = 0; r < 8; r++) begin
      bus_read(3'(r), rd);
      chk_val("reset_read", rd, 32'd0);
    end

    // Edge latching on source 0.
    bus_write(c_mode, 32'h1);
    bus_write(c_en, 32'h1);
    IRQ_In = 16'h0001;
    bus_idle();
    bus_idle();
    chk_val("edge_si_early", {24'd0, SI_Int}, 32'd0);
    IRQ_In = 16'h0000;
    bus_read(c_pend, rd);
    chk_val("edge_pend", rd, 32'h1);
    bus_idle();
    chk_val("edge_si", {24'd0, SI_Int}, 32'h1);
    bus_write(c_clr, 32'h1);
    bus_read(c_pend, rd);
    chk_val("edge_pend_clr", rd, 32'h0);
    bus_idle();
    chk_val("edge_si_clr", {24'd0, SI_Int}, 32'h0);

    // Level tracking on source 2; CLR has no effect.
    bus_write(c_mode, 32'h0);
    bus_write(c_en, 32'h4);
    IRQ_In = 16'h0004;
    bus_idle();
    bus_idle();
    chk_val("level_si_2", {24'd0, SI_Int}, 32'h0);
    bus_idle();
    chk_val("level_si_3", {24'd0, SI_Int}, 32'h4);
    bus_write(c_clr, 32'h4);
    chk_val("level_clr_ign", {24'd0, SI_Int}, 32'h4);
    IRQ_In = 16'h0000;
    bus_idle();
    bus_idle();
    chk_val("level_fall_2", {24'd0, SI_Int}, 32'h4);
    bus_idle();
    chk_val("level_fall_3", {24'd0, SI_Int}, 32'h0);

    // EIC priority: sources 9 and 3 latched, lowest wins.
    bus_write(c_mode, 32'hFFFF);
    bus_write(c_en, 32'hFFFF);
    bus_write(c_ctrl, 32'h1);
    IRQ_In = 16'h0208;
    repeat (4) bus_idle();
    IRQ_In = 16'h0000;
    bus_read(c_vec, rd);
    chk_val("eic_vec_reg", rd, 32'd4);
    bus_idle();
    chk_val("eic_vector_4", {26'd0, EIC_Vector}, 32'd4);
    chk_val("eic_si_zero", {24'd0, SI_Int}, 32'd0);
    bus_write(c_clr, 32'h0008);
    bus_idle();
    chk_val("eic_vector_10", {26'd0, EIC_Vector}, 32'd10);
    bus_read(c_vec, rd);
    chk_val("eic_vec_reg_10", rd, 32'd10);
    bus_write(c_clr, 32'h0200);

    // Set and clear on the same edge: set wins.
    IRQ_In = 16'h0002;
    bus_idle();
    bus_write(c_clr, 32'h2);
    bus_read(c_pend, rd);
    chk_val("collision_pend", rd, 32'h2);
    IRQ_In = 16'h0000;
    bus_write(c_clr, 32'h2);

    // Bits above N_SRC and back-to-back write/read.
    write_then_read(c_en, 32'hFFFF_FFFF, rd);
    chk_val("en_upper_bits", rd, 32'h0000_FFFF);
    write_then_read(c_ctrl, 32'hFFFF_FFFE, rd);
    chk_val("ctrl_bit0", rd, 32'h0);
    bus_read(c_rsvd, rd);
    chk_val("rsvd_read", rd, 32'h0);

    // Legacy fold: source 13 lands on pin 5.
    bus_write(c_mode, 32'h0);
    bus_write(c_en, 32'h2000);
    IRQ_In = 16'h2000;
    repeat (4) bus_idle();
    chk_val("fold_si", {24'd0, SI_Int}, 32'h20);
    bus_read(c_act, rd);
    chk_val("fold_act", rd, 32'h2000);

    // Asynchronous reset clears outputs without a clock edge.
    HRESETn = 1'b0;
    model_reset();
    #2;
    chk_val("async_rst_si", {24'd0, SI_Int}, 32'h0);
    chk_val("async_rst_vec", {26'd0, EIC_Vector}, 32'h0);
    chk_val("async_rst_rdata", HRDATA, 32'h0);
    repeat (2) tick();
    HRESETn = 1'b1;
    repeat (4) bus_idle();
    chk_val("post_rst_quiet", {24'd0, SI_Int}, 32'h0);
    IRQ_In = 16'h0000;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0)
        IRQ_In = IRQ_In ^ 16'(32'd1 << $urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0, 1: bus_idle();
        2:    bus_write(3'($urandom_range(0, 7)), $urandom);
        3:    bus_read(3'($urandom_range(0, 7)), rd);
        4:    write_then_read(3'($urandom_range(0, 7)), $urandom, rd);
        default: bus_write(c_clr, $urandom);
      endcase
    end
    bus_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_mfp_ahb_intc
`default_nettype wire
